// File: rtl/seq_mdu.sv
// seq_mdu: multi-cycle multiply/divide unit for the execute stage.
// Implements mullw/mulhw/mulhwu/divw/divwu using a radix-2 iterative
// datapath: shift-add on magnitudes for multiply, restoring shift-subtract
// on magnitudes for divide. Sign correction, overflow detection and the CR0
// field are all computed in a single fix-up cycle.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         request; taken only in IDLE with flush=0 and no done pulse
//   flush         abort the in-flight operation
//   Op            operation code, sampled with start
//   A, B          operands (bit 0 = MSB), sampled with start
//   so_in         current XER[SO], sampled with start
//   busy          operation in flight (pipeline stalls on it)
//   done          one-cycle completion pulse
//   C             result (bit 0 = MSB)
//   OV            overflow of the completed operation
//   D             CR0 field {LT,GT,EQ,SO}

`ifndef MDUOp_WIDTH
`define MDUOp_WIDTH 3
`endif
`ifndef MDUOp_MULW
`define MDUOp_MULW 0
`endif
`ifndef MDUOp_MULH
`define MDUOp_MULH 1
`endif
`ifndef MDUOp_MULHU
`define MDUOp_MULHU 2
`endif
`ifndef MDUOp_DIVW
`define MDUOp_DIVW 3
`endif
`ifndef MDUOp_DIVWU
`define MDUOp_DIVWU 4
`endif

module seq_mdu #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned OP_WIDTH = `MDUOp_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                flush,
    input  logic [OP_WIDTH-1:0] Op,
    input  logic [0:WIDTH-1]    A,
    input  logic [0:WIDTH-1]    B,
    input  logic                so_in,
    output logic                busy,
    output logic                done,
    output logic [0:WIDTH-1]    C,
    output logic                OV,
    output logic [3:0]          D
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [OP_WIDTH-1:0] OP_MULW  = OP_WIDTH'(`MDUOp_MULW);
    localparam logic [OP_WIDTH-1:0] OP_MULH  = OP_WIDTH'(`MDUOp_MULH);
    localparam logic [OP_WIDTH-1:0] OP_MULHU = OP_WIDTH'(`MDUOp_MULHU);
    localparam logic [OP_WIDTH-1:0] OP_DIVW  = OP_WIDTH'(`MDUOp_DIVW);
    localparam logic [OP_WIDTH-1:0] OP_DIVWU = OP_WIDTH'(`MDUOp_DIVWU);

    // Control and latched-operand state
    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OP_WIDTH-1:0] op_q, op_d;
    logic                a_neg_q, a_neg_d;
    logic                b_neg_q, b_neg_d;
    logic                b_zero_q, b_zero_d;
    logic                smin_m1_q, smin_m1_d;
    logic                so_q, so_d;

    // Iterative datapath: acc = {partial product | remainder, multiplier | quotient}
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]       acc_q, acc_d;

    // Registered outputs
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    c_q, c_d;
    logic                ov_q, ov_d;
    logic [3:0]          cr_q, cr_d;

    // Combinational helpers
    logic [WIDTH-1:0]    a_in, b_in, a_mag, b_mag;
    logic                in_signed, accept, is_div, neg;
    logic [WIDTH:0]      mul_sum, div_trial;
    logic [PW-1:0]       prod_s;
    logic [WIDTH-1:0]    quo_s, res;
    logic                ovf, lt, eq;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            b_zero_q  <= 1'b0;
            smin_m1_q <= 1'b0;
            so_q      <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            c_q       <= '0;
            ov_q      <= 1'b0;
            cr_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            b_zero_q  <= b_zero_d;
            smin_m1_q <= smin_m1_d;
            so_q      <= so_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            c_q       <= c_d;
            ov_q      <= ov_d;
            cr_q      <= cr_d;
        end
    end

    // Operand conditioning, one iteration step, fix-up result, next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        b_zero_d  = b_zero_q;
        smin_m1_d = smin_m1_q;
        so_d      = so_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        c_d       = c_q;
        ov_d      = ov_q;
        cr_d      = cr_q;

        a_in      = A;
        b_in      = B;
        in_signed = (Op == OP_MULW) || (Op == OP_MULH) || (Op == OP_DIVW);
        a_mag     = (in_signed && a_in[WIDTH-1]) ? -a_in : a_in;
        b_mag     = (in_signed && b_in[WIDTH-1]) ? -b_in : b_in;
        // No accept during the done pulse so the next start lands the cycle after it
        accept    = (state_q == S_IDLE) && start && !flush && !done_q;

        is_div    = (op_q == OP_DIVW) || (op_q == OP_DIVWU);
        mul_sum   = {1'b0, acc_q[PW-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
        // Shifted partial remainder minus divisor; bit WIDTH set means borrow
        div_trial = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mcand_q};

        neg       = a_neg_q ^ b_neg_q;
        prod_s    = neg ? -acc_q : acc_q;
        quo_s     = neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        res       = '0;
        ovf       = 1'b0;
        case (op_q)
            OP_MULW: begin
                res = prod_s[WIDTH-1:0];
                ovf = (prod_s[PW-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
            end
            OP_MULH:  res = prod_s[PW-1:WIDTH];
            OP_MULHU: res = acc_q[PW-1:WIDTH];
            OP_DIVW: begin
                if (b_zero_q || smin_m1_q) begin
                    ovf = 1'b1;
                end else begin
                    res = quo_s;
                end
            end
            OP_DIVWU: begin
                if (b_zero_q) begin
                    ovf = 1'b1;
                end else begin
                    res = acc_q[WIDTH-1:0];
                end
            end
            default: res = '0;
        endcase
        lt = res[WIDTH-1];
        eq = (res == '0);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_CALC;
                    cnt_d     = '0;
                    op_d      = Op;
                    a_neg_d   = in_signed && a_in[WIDTH-1];
                    b_neg_d   = in_signed && b_in[WIDTH-1];
                    b_zero_d  = (b_in == '0);
                    smin_m1_d = (a_in == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_in);
                    so_d      = so_in;
                    mcand_d   = b_mag;
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    busy_d    = 1'b1;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    busy_d = 1'b1;
                    if (is_div) begin
                        if (!div_trial[WIDTH]) begin
                            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {acc_q[PW-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    state_d = S_DONE;
                    c_d     = res;
                    ov_d    = ovf;
                    cr_d    = {lt, !lt && !eq, eq, so_q | ovf};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign C    = c_q;
    assign OV   = ov_q;
    assign D    = cr_q;

endmodule

// File: doc/seq_mdu.md
Name: seq_mdu

Overview:
- Multi-cycle, parametrised successor to the combinational multiply/divide unit in the execute stage.
- Performs PowerPC mullw/mulhw/mulhwu/divw/divwu with a radix-2 iterative datapath, not a full-width array.
- Uses a start/busy/done handshake, so the pipeline stalls on busy.
- Produces the result, an overflow flag for "o" forms, and CR0 bits including SO.

Parameters:
- WIDTH, 32: operand/result width in bits, even, >= 8.
- OP_WIDTH, `MDUOp_WIDTH: width of the operation code.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0 and flush=0.
- flush  in  1  abort in-flight operation (pipeline flush).
- Op  in  OP_WIDTH  `MDUOp_MULW / _MULH / _MULHU / _DIVW / _DIVWU; sampled with start.
- A  in  WIDTH  operand A / dividend; bit 0 = MSB; sampled with start.
- B  in  WIDTH  operand B / divisor; bit 0 = MSB; sampled with start.
- so_in  in  1  current XER[SO].
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- C  out  WIDTH  result.
- OV  out  1  overflow for the completed operation.
- D  out  4  {LT,GT,EQ,SO} CR0 field for C.

Behaviour:
- Reset: asynchronous on rst=1, regardless of state. busy=0, done=0, C=0, OV=0, D=0, FSM=IDLE. No done ever follows reset.
- FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - IDLE: on start & !flush, latch Op/A/B/so_in, set busy=1, go to CALC.
  - CALC: exactly WIDTH cycles. Multiply is shift-add on magnitudes into a 2*WIDTH product. Divide is restoring shift-subtract on magnitudes.
  - FIX: 1 cycle. Apply sign correction (negate if operand signs differ for signed ops; remainder discarded), detect overflow, register C/OV/D.
  - DONE: done=1 for exactly one cycle, busy=0 in this cycle, then IDLE.
- Latency: done asserted WIDTH+2 rising edges after the edge that accepted start; fixed for every Op, including error cases.
- Back-to-back: start in the DONE cycle is ignored. The next start is accepted in IDLE, the cycle after done.
- start while busy=1: ignored; latched operands unchanged.
- flush while busy=1: go to IDLE next edge; busy=0, no done, C/OV/D keep previous values.
- flush in IDLE: start in the same cycle is not accepted.
- C/OV/D hold from FIX until the next FIX; they never change during CALC.
- Op arithmetic:
  - MULW: signed; C = low WIDTH bits. OV=1 iff the high half is not the sign-extension of C[0].
  - MULH: signed; C = high WIDTH bits; OV=0.
  - MULHU: unsigned; C = high WIDTH bits; OV=0.
  - DIVW: signed, quotient truncated toward zero.
  - DIVWU: unsigned quotient.
- Divide errors: B=0 (both divides), or DIVW with A=most-negative and B=-1, give C=0, OV=1. The iteration still runs; the result is forced in FIX.
- Unknown Op: accepted, completes with C=0, OV=0.
- CR0:
  - LT = C[0].
  - EQ = (C==0).
  - GT = !LT & !EQ.
  - SO = latched so_in | OV.

Test Plan (WIDTH=32):
- MULW A=0x00010000, B=0x00010000, so_in=0 -> done exactly 34 edges after start; C=0x00000000, OV=1, D=4'b0011; busy high for 33 cycles.
- MULH A=0xFFFFFFFD(-3), B=5 -> C=0xFFFFFFFF, OV=0, D=4'b1000. Then MULHU A=0xFFFFFFFF, B=2 -> C=0x00000001, D=4'b0100.
- DIVW A=0xFFFFFFF9(-7), B=2 -> C=0xFFFFFFFD, OV=0, D=4'b1000. DIVWU same operands -> C=0x7FFFFFFC, D=4'b0100.
- DIVW 0x80000000/0xFFFFFFFF -> C=0, OV=1, D=4'b0011. DIVWU 5/0 with so_in=1 -> C=0, OV=1, D=4'b0011. Both at 34-edge latency.
- Control cases:
  - Second start 5 cycles into an op: ignored, result matches the first op.
  - flush at cycle 10: busy=0 next edge, no done, C unchanged; a new start is then accepted and completes normally.
  - rst asserted mid-CALC: all outputs 0 immediately, no done.
